// File: rtl/char_stream_fifo_pkg.sv
// Shared definitions for the G-code character stream FIFO.
// Holds the default depth, the read-FSM state encoding and the ASCII
// lowercase bounds used by the optional case fold
// (enabled with CHAR_STREAM_TO_UPPER_EN).
package char_stream_fifo_pkg;

  // Default number of byte entries; must be a power of two and at least 2.
  localparam int CHAR_STREAM_DEPTH = 16;

  // Lowercase ASCII range 'a'..'z'.
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;

  // Read handshake states: idle and accepting, popping, reporting completion.
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_POP  = 2'd1,
    RD_DONE = 2'd2
  } rd_state_t;

  // Map 'a'..'z' onto 'A'..'Z' by clearing bit 5; other bytes pass through.
  function automatic logic [7:0] fold_upper(input logic [7:0] ch);
    logic [7:0] folded;
    folded = ch;
    if (ch >= ASCII_LOWER_A && ch <= ASCII_LOWER_Z) begin
      folded = ch & 8'hDF;
    end
    return folded;
  endfunction

endpackage : char_stream_fifo_pkg

// File: rtl/char_stream_fifo_if.sv
// Handshake bundle between the serial receive path / parser and the
// character stream FIFO. The slave modport is the FIFO side; the master
// modport is the side that writes bytes, requests pops and flushes.
interface char_stream_fifo_if;
  import char_stream_fifo_pkg::*;

  logic       wr_trigger;
  logic [7:0] wr_data;
  logic       is_full;
  logic       rd_trigger;
  logic       rd_rdy;
  logic       rd_done;
  logic       is_empty;
  logic [7:0] char_out;
  logic       flush;
  logic       overflow;
  logic       underflow;

  modport slave (
    input  wr_trigger, wr_data, rd_trigger, flush,
    output is_full, rd_rdy, rd_done, is_empty, char_out, overflow, underflow
  );

  modport master (
    output wr_trigger, wr_data, rd_trigger, flush,
    input  is_full, rd_rdy, rd_done, is_empty, char_out, overflow, underflow
  );

endinterface : char_stream_fifo_if

// File: rtl/char_stream_rd_fsm.sv
// Read handshake state machine for the character stream FIFO.
// A trigger accepted in IDLE leads to one POP cycle and one DONE cycle, so
// pops are spaced at least three enabled cycles apart. The FSM never looks
// at flush: an accepted trigger always produces its rd_done pulse, and the
// storage side decides whether the pop actually removes a byte.
module char_stream_rd_fsm
  import char_stream_fifo_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  input  logic rd_trigger,
  output logic rd_rdy,
  output logic rd_done,
  output logic pop_en
);

  rd_state_t state_q;
  rd_state_t state_d;

  // State register; a low clock enable freezes the state and therefore the
  // rd_done level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RD_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs of the read handshake.
  always_comb begin
    state_d = state_q;
    rd_rdy  = 1'b0;
    rd_done = 1'b0;
    pop_en  = 1'b0;
    unique case (state_q)
      RD_IDLE: begin
        rd_rdy = 1'b1;
        if (rd_trigger) begin
          state_d = RD_POP;
        end
      end
      RD_POP: begin
        pop_en  = 1'b1;
        state_d = RD_DONE;
      end
      RD_DONE: begin
        rd_done = 1'b1;
        state_d = RD_IDLE;
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

endmodule : char_stream_rd_fsm

// File: rtl/char_stream_fifo.sv
// Byte FIFO buffering G-code characters between the serial receiver and
// the parser's subparsers. Storage, pointers, occupancy count, sticky
// error flags and the popped character live here; the read handshake is
// in char_stream_rd_fsm.
// Optional feature: define CHAR_STREAM_TO_UPPER_EN to fold 'a'..'z' to
// uppercase as bytes are written.
// The active-low reset asserts asynchronously; its release must be
// synchronous to clk.
module char_stream_fifo
  import char_stream_fifo_pkg::*;
#(
  parameter int DEPTH    = CHAR_STREAM_DEPTH,
  parameter int PTR_BITS = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  char_stream_fifo_if.slave      bus
);

  localparam logic [PTR_BITS:0]   CNT_ONE  = 1;
  localparam logic [PTR_BITS:0]   CNT_FULL = DEPTH[PTR_BITS:0];
  localparam logic [PTR_BITS-1:0] PTR_ONE  = 1;

  logic [7:0]          mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;
  logic [PTR_BITS:0]   count;
  logic [7:0]          char_q;
  logic                overflow_q;
  logic                underflow_q;

  logic                full;
  logic                empty;
  logic                pop_en;
  logic                write_ok;
  logic                pop_ok;
  logic [7:0]          store_data;

  char_stream_rd_fsm u_rd_fsm (
    .clk        (clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .rd_trigger (bus.rd_trigger),
    .rd_rdy     (bus.rd_rdy),
    .rd_done    (bus.rd_done),
    .pop_en     (pop_en)
  );

  // Occupancy flags come straight from the count of the current cycle, so
  // a same-cycle pop never makes room for a write into a full FIFO.
  always_comb begin
    full     = (count == CNT_FULL);
    empty    = (count == '0);
    write_ok = bus.wr_trigger && !full && !bus.flush;
    pop_ok   = pop_en && !empty && !bus.flush;
  end

  // Byte as it will be stored, optionally folded to uppercase.
  always_comb begin
`ifdef CHAR_STREAM_TO_UPPER_EN
    store_data = fold_upper(bus.wr_data);
`else
    store_data = bus.wr_data;
`endif
  end

  // Storage array; contents need no reset because the count guards reads.
  always_ff @(posedge clk) begin
    if (clk_en && write_ok) begin
      mem[wr_ptr] <= store_data;
    end
  end

  // Pointers and count; flush empties the FIFO and beats any write or pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (write_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (write_ok && !pop_ok) begin
          count <= count + CNT_ONE;
        end else if (pop_ok && !write_ok) begin
          count <= count - CNT_ONE;
        end
      end
    end
  end

  // Popped character; it holds through empty pops and flushes so the
  // consumer always sees the last real byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_q <= 8'h00;
    end else if (clk_en && pop_ok) begin
      char_q <= mem[rd_ptr];
    end
  end

  // Sticky error flags; only reset or flush clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clk_en) begin
      if (bus.flush) begin
        overflow_q  <= 1'b0;
        underflow_q <= 1'b0;
      end else begin
        if (bus.wr_trigger && full) begin
          overflow_q <= 1'b1;
        end
        if (pop_en && empty) begin
          underflow_q <= 1'b1;
        end
      end
    end
  end

  assign bus.is_full   = full;
  assign bus.is_empty  = empty;
  assign bus.char_out  = char_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  // The occupancy count can never exceed the storage depth.
  a_count_bound : assert property (
    @(posedge clk) disable iff (!reset) count <= CNT_FULL
  );

  // Full and empty are mutually exclusive for any legal depth.
  a_full_empty_excl : assert property (
    @(posedge clk) disable iff (!reset) !(full && empty)
  );

endmodule : char_stream_fifo
